relin_pass_scheduler: RTL and testbench
=======================================

Name: relin_pass_scheduler

Overview:
- Sequences one full relinearization of a c2 polynomial through relin_unit.
- Fetches c2 tiles from a coefficient buffer and issues them with the tile handshake.
- Runs two passes: key_select 0 (c0 keys), then key_select 1 (c1 keys).
- Collects output tiles, tags each with pass and index, and flags protocol errors. Sits between the c2 buffer/top controller and relin_unit.

Parameters:
DATA_WIDTH, 64, coefficient width
C2_TILE_WIDTH, 8, coefficients per tile
C2_WIDTH, 512, c2 polynomial length; NUM_TILES = C2_WIDTH/C2_TILE_WIDTH (integer, required)
OUT_TILES_PER_PASS, 64, output tiles expected from relin_unit per pass
DRAIN_TIMEOUT, 4096, max cycles in DRAIN before error
ADDR_W, $clog2(NUM_TILES) (min 1), tile address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  begin two-pass run (pulse)
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at end of run
err_o  out  1  sticky error; cleared by rst or accepted start_i
buf_rd_en_o  out  1  buffer read strobe
buf_rd_addr_o  out  ADDR_W  tile address
buf_rd_data_i  in  C2_TILE_WIDTH*DATA_WIDTH  tile data, valid 1 cycle after rd_en
relin_valid_o  out  1  tile valid to relin_unit (one-cycle pulse)
relin_key_select_o  out  1  current pass
relin_coeff_o  out  C2_TILE_WIDTH*DATA_WIDTH  tile to relin_unit
relin_ready_i  in  1  relin_unit requests next tile
relin_out_valid_i  in  1  relin_unit output tile valid
relin_out_coeff_i  in  C2_TILE_WIDTH*DATA_WIDTH  relin_unit output tile
relin_done_i  in  1  relin_unit pass complete
out_valid_o  out  1  forwarded output valid
out_key_select_o  out  1  pass of forwarded tile
out_tile_idx_o  out  $clog2(OUT_TILES_PER_PASS)+1  index within pass
out_coeff_o  out  C2_TILE_WIDTH*DATA_WIDTH  forwarded tile

Behaviour:
- Reset (async, any state, including mid-run):
  - State IDLE; all counters 0.
  - All outputs 0: busy_o, done_o, err_o, rd_en, relin_valid_o, key_select, out_valid_o, data buses.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT_READY, DRAIN, SWITCH, FINISH.
- IDLE:
  - start_i=1 -> FETCH; tile_idx=0; key_sel=0; err_o cleared; busy_o=1 from next cycle.
  - start_i while busy is ignored.
- FETCH: rd_en=1 for one cycle with addr=tile_idx -> LOAD.
- LOAD: capture buf_rd_data_i into tile register -> ISSUE.
- ISSUE: relin_valid_o=1 for exactly one cycle; relin_coeff_o holds the tile register (stable until the next ISSUE) -> WAIT_READY.
- WAIT_READY: wait for relin_ready_i=1 (level, sampled at posedge). Then:
  - tile_idx == NUM_TILES-1 -> DRAIN;
  - otherwise tile_idx+1 -> FETCH.
  - Minimum spacing between issues is 4 cycles.
- DRAIN:
  - relin_done_i latched into a sticky flag.
  - Exit when flag=1 and out_count == OUT_TILES_PER_PASS.
  - Timeout counter increments each DRAIN cycle; reaching DRAIN_TIMEOUT sets err_o and exits anyway.
  - Exit target: key_sel=0 -> SWITCH; key_sel=1 -> FINISH.
- SWITCH (1 cycle): key_sel=1; tile_idx, out_count, done flag, timeout cleared -> FETCH.
- FINISH: done_o=1 for one cycle; busy_o=0 next cycle -> IDLE.
- Output forwarding (any busy state):
  - relin_out_valid_i=1 registers coeff to out_coeff_o, out_valid_o=1, out_key_select_o=key_sel, out_tile_idx_o=out_count; then out_count++. Latency 1 cycle.
  - If out_count already == OUT_TILES_PER_PASS: tile not forwarded, err_o set.
  - relin_out_valid_i in IDLE: ignored, err_o set.
- relin_key_select_o = key_sel; constant for the whole pass.
- relin_done_i before DRAIN is latched; it does not end issuing early.
- Simultaneous relin_out_valid_i and the DRAIN exit condition in one cycle: that tile is counted before the exit compare.
- buf_rd_addr_o wraps never: tile_idx is bounded by NUM_TILES-1.

Test Plan:
- C2_WIDTH=32, C2_TILE_WIDTH=8, OUT_TILES_PER_PASS=4; start, relin_ready_i tied 1, 4 out tiles + done per pass -> addrs 0,1,2,3 twice; key_select 0 then 1; 8 relin_valid_o pulses; out_tile_idx 0..3 per pass; done_o pulses once; err_o=0.
- Same config, relin_ready_i held low 10 cycles after the 2nd tile -> no 3rd rd_en until ready seen; relin_valid_o never asserted twice per tile.
- relin_done_i never asserted, DRAIN_TIMEOUT=16 -> err_o=1 exactly 16 cycles into DRAIN of pass 0; run still completes with done_o.
- 5 out tiles in pass 0 -> 5th not forwarded, err_o=1; pass 1 indices restart at 0.
- rst asserted mid-pass 1 in WAIT_READY -> all outputs 0 immediately; new start_i runs a clean pass 0 from addr 0.
- start_i pulsed while busy, and relin_out_valid_i in IDLE -> start ignored (no restart); IDLE output sets err_o, which the next accepted start clears.

Source files
------------

// File: rtl/relin_pass_scheduler.sv
// rtl/relin_pass_scheduler.sv - two-pass relinearization sequencer in front of relin_unit
//
// Purpose: walks the c2 polynomial tile by tile out of the coefficient buffer,
// hands each tile to relin_unit, and repeats the walk for key_select 0 and 1.
// Output tiles returned by relin_unit are forwarded with their pass and index.
// Protocol violations (surplus tiles, tiles while idle, drain timeout) set a
// sticky error.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start_i                   begin a two-pass run (ignored while busy)
//   busy_o, done_o, err_o     run status, end-of-run pulse, sticky error
//   buf_rd_en_o/addr_o/data_i c2 tile buffer read port (data one cycle after en)
//   relin_valid_o/key_select_o/coeff_o, relin_ready_i   tile issue handshake
//   relin_out_valid_i/coeff_i, relin_done_i            relin_unit results
//   out_valid_o/key_select_o/tile_idx_o/coeff_o         forwarded result tiles
module relin_pass_scheduler #(
  parameter int DATA_WIDTH         = 64,
  parameter int C2_TILE_WIDTH      = 8,
  parameter int C2_WIDTH           = 512,
  parameter int OUT_TILES_PER_PASS = 64,
  parameter int DRAIN_TIMEOUT      = 4096,
  parameter int ADDR_W = ((C2_WIDTH / C2_TILE_WIDTH) > 1) ? $clog2(C2_WIDTH / C2_TILE_WIDTH) : 1,
  localparam int TILE_W = C2_TILE_WIDTH * DATA_WIDTH,
  localparam int IDX_W  = $clog2(OUT_TILES_PER_PASS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              buf_rd_en_o,
  output logic [ADDR_W-1:0] buf_rd_addr_o,
  input  logic [TILE_W-1:0] buf_rd_data_i,
  output logic              relin_valid_o,
  output logic              relin_key_select_o,
  output logic [TILE_W-1:0] relin_coeff_o,
  input  logic              relin_ready_i,
  input  logic              relin_out_valid_i,
  input  logic [TILE_W-1:0] relin_out_coeff_i,
  input  logic              relin_done_i,
  output logic              out_valid_o,
  output logic              out_key_select_o,
  output logic [IDX_W-1:0]  out_tile_idx_o,
  output logic [TILE_W-1:0] out_coeff_o
);

  localparam int NUM_TILES = C2_WIDTH / C2_TILE_WIDTH;
  localparam int TO_W      = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_READY, DRAIN, SWITCH, FINISH
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] tile_idx;
  logic              key_sel;
  logic              done_flag;
  logic [IDX_W-1:0]  out_count;
  logic [TO_W-1:0]   drain_cnt;
  logic [TILE_W-1:0] tile_reg;

  logic out_full;
  logic out_accept;
  logic out_reject;
  logic pass_complete;
  logic drain_timeout;
  logic drain_exit;
  logic last_tile;

  assign out_full   = (out_count == IDX_W'(OUT_TILES_PER_PASS));
  assign out_accept = busy_o && relin_out_valid_i && !out_full;
  assign out_reject = relin_out_valid_i && (!busy_o || out_full);

  // A tile arriving in the same cycle as the exit check already counts.
  assign pass_complete = (done_flag || relin_done_i) &&
                         ((out_count + IDX_W'(out_accept)) == IDX_W'(OUT_TILES_PER_PASS));
  assign drain_timeout = (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1));
  assign drain_exit    = pass_complete || drain_timeout;
  assign last_tile     = (tile_idx == ADDR_W'(NUM_TILES - 1));

  assign buf_rd_addr_o      = tile_idx;
  assign relin_key_select_o = key_sel;
  assign relin_coeff_o      = tile_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy_o        = (state != IDLE);
    done_o        = 1'b0;
    buf_rd_en_o   = 1'b0;
    relin_valid_o = 1'b0;
    case (state)
      IDLE:       if (start_i) state_next = FETCH;
      FETCH: begin
        buf_rd_en_o = 1'b1;
        state_next  = LOAD;
      end
      LOAD:       state_next = ISSUE;
      ISSUE: begin
        relin_valid_o = 1'b1;
        state_next    = WAIT_READY;
      end
      WAIT_READY: if (relin_ready_i) state_next = last_tile ? DRAIN : FETCH;
      DRAIN:      if (drain_exit) state_next = key_sel ? FINISH : SWITCH;
      SWITCH:     state_next = FETCH;
      FINISH: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_idx         <= '0;
      key_sel          <= 1'b0;
      done_flag        <= 1'b0;
      out_count        <= '0;
      drain_cnt        <= '0;
      tile_reg         <= '0;
      err_o            <= 1'b0;
      out_valid_o      <= 1'b0;
      out_key_select_o <= 1'b0;
      out_tile_idx_o   <= '0;
      out_coeff_o      <= '0;
    end else begin
      out_valid_o <= 1'b0;

      // relin_done_i may arrive before DRAIN; remember it for the exit check.
      if (busy_o && relin_done_i) done_flag <= 1'b1;

      if (out_accept) begin
        out_valid_o      <= 1'b1;
        out_key_select_o <= key_sel;
        out_tile_idx_o   <= out_count;
        out_coeff_o      <= relin_out_coeff_i;
        out_count        <= out_count + IDX_W'(1);
      end
      if (out_reject) err_o <= 1'b1;

      // State-specific updates come last so pass/run clears win.
      case (state)
        IDLE: if (start_i) begin
          tile_idx  <= '0;
          key_sel   <= 1'b0;
          done_flag <= 1'b0;
          out_count <= '0;
          drain_cnt <= '0;
          if (!out_reject) err_o <= 1'b0;
        end
        LOAD:       tile_reg <= buf_rd_data_i;
        WAIT_READY: if (relin_ready_i && !last_tile) tile_idx <= tile_idx + ADDR_W'(1);
        DRAIN: begin
          drain_cnt <= drain_cnt + TO_W'(1);
          if (drain_timeout && !pass_complete) err_o <= 1'b1;
        end
        SWITCH: begin
          key_sel   <= 1'b1;
          tile_idx  <= '0;
          done_flag <= 1'b0;
          out_count <= '0;
          drain_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_relin_pass_scheduler.sv
// tb/tb_relin_pass_scheduler.sv - self-checking bench for relin_pass_scheduler
module tb_relin_pass_scheduler;

  localparam int DW     = 16;
  localparam int TW     = 8;
  localparam int C2W    = 32;
  localparam int OUTN   = 4;
  localparam int DTO    = 16;
  localparam int NT     = C2W / TW;
  localparam int TILE_W = DW * TW;

  typedef struct packed {
    logic              key;
    logic [2:0]        idx;
    logic [TILE_W-1:0] coeff;
  } tile_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              busy_o, done_o, err_o;
  logic              buf_rd_en_o;
  logic [1:0]        buf_rd_addr_o;
  logic [TILE_W-1:0] buf_rd_data_i = '0;
  logic              relin_valid_o, relin_key_select_o;
  logic [TILE_W-1:0] relin_coeff_o;
  logic              relin_ready_i = 1'b1;
  logic              relin_out_valid_i = 1'b0;
  logic [TILE_W-1:0] relin_out_coeff_i = '0;
  logic              relin_done_i = 1'b0;
  logic              out_valid_o, out_key_select_o;
  logic [2:0]        out_tile_idx_o;
  logic [TILE_W-1:0] out_coeff_o;

  relin_pass_scheduler #(
    .DATA_WIDTH(DW), .C2_TILE_WIDTH(TW), .C2_WIDTH(C2W),
    .OUT_TILES_PER_PASS(OUTN), .DRAIN_TIMEOUT(DTO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o), .buf_rd_data_i(buf_rd_data_i),
    .relin_valid_o(relin_valid_o), .relin_key_select_o(relin_key_select_o),
    .relin_coeff_o(relin_coeff_o), .relin_ready_i(relin_ready_i),
    .relin_out_valid_i(relin_out_valid_i), .relin_out_coeff_i(relin_out_coeff_i),
    .relin_done_i(relin_done_i),
    .out_valid_o(out_valid_o), .out_key_select_o(out_key_select_o),
    .out_tile_idx_o(out_tile_idx_o), .out_coeff_o(out_coeff_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Environment state: c2 buffer contents, relin_unit behaviour, recorded traffic.
  logic [TILE_W-1:0] mem [NT];
  int    cyc;
  int    n_out [2];
  bit    send_done;
  int    stall_pass, stall_after, stall_len, hold_lo, hold_hi;
  int    pass_issues [2];
  int    emit_left, emit_k, emit_key;
  bit    done_pending;
  int    rd_q[$], rd_cyc[$], iss_key[$], iss_cyc[$];
  logic [TILE_W-1:0] iss_coeff[$];
  tile_t out_q[$], exp_q[$];
  int    exp_reject, done_cnt, err_rise;

  function automatic logic [TILE_W-1:0] rand_tile();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_rec(input int n0, input int n1, input bit dn);
    for (int i = 0; i < NT; i++) mem[i] = rand_tile();
    n_out[0] = n0; n_out[1] = n1; send_done = dn;
    stall_after = 0; stall_pass = 0; stall_len = 0; hold_lo = -1; hold_hi = -1;
    pass_issues[0] = 0; pass_issues[1] = 0;
    emit_left = 0; emit_k = 0; emit_key = 0; done_pending = 0;
    rd_q.delete(); rd_cyc.delete(); iss_key.delete(); iss_cyc.delete(); iss_coeff.delete();
    out_q.delete(); exp_q.delete();
    exp_reject = 0; done_cnt = 0; err_rise = -1;
  endtask

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic step();
    tile_t t;
    int    k;
    logic [TILE_W-1:0] d;
    @(negedge clk);
    cyc++;
    if (buf_rd_en_o) begin
      rd_q.push_back(int'(buf_rd_addr_o));
      rd_cyc.push_back(cyc);
      buf_rd_data_i = mem[buf_rd_addr_o];
    end
    if (relin_valid_o) begin
      k = int'(relin_key_select_o);
      iss_key.push_back(k);
      iss_coeff.push_back(relin_coeff_o);
      iss_cyc.push_back(cyc);
      pass_issues[k]++;
      if (stall_after != 0 && k == stall_pass && pass_issues[k] == stall_after) begin
        hold_lo = cyc;
        hold_hi = cyc + stall_len;
      end
      if (pass_issues[k] == NT) begin
        emit_left = n_out[k]; emit_k = 0; emit_key = k; done_pending = send_done;
      end
    end
    if (out_valid_o) begin
      t.key = out_key_select_o; t.idx = out_tile_idx_o; t.coeff = out_coeff_o;
      out_q.push_back(t);
    end
    if (done_o) done_cnt++;
    if (err_o && err_rise < 0) err_rise = cyc;

    relin_out_valid_i = 1'b0;
    relin_done_i      = 1'b0;
    if (emit_left > 0) begin
      d = rand_tile();
      relin_out_valid_i = 1'b1;
      relin_out_coeff_i = d;
      if (emit_k < OUTN) begin
        t.key = emit_key[0]; t.idx = 3'(emit_k); t.coeff = d;
        exp_q.push_back(t);
      end else begin
        exp_reject++;
      end
      emit_k++;
      emit_left--;
    end else if (done_pending) begin
      relin_done_i = 1'b1;
      done_pending = 0;
    end
    relin_ready_i = !(cyc >= hold_lo && cyc < hold_hi);
  endtask

  task automatic kick();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic run(input int max_cyc);
    for (int n = 0; n < max_cyc && done_cnt == 0; n++) step();
    step();
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if ({busy_o, done_o, err_o, buf_rd_en_o, relin_valid_o, relin_key_select_o, out_valid_o} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000", {busy_o, done_o, err_o, buf_rd_en_o, relin_valid_o, relin_key_select_o, out_valid_o});
    else passed++;
    total++; if ({relin_coeff_o, out_coeff_o, out_tile_idx_o, buf_rd_addr_o} !== '0)
      $display("FAIL reset_buses got nonzero want zero"); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    clear_rec(OUTN, OUTN, 1);
    kick();
    total++; if (busy_o !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_o); else passed++;
    run(400);
    total++; if (rd_q.size() != 2 * NT) $display("FAIL basic_rd_count got %0d want %0d", rd_q.size(), 2 * NT); else passed++;
    for (int i = 0; i < rd_q.size() && i < 2 * NT; i++) begin
      total++; if (rd_q[i] != i % NT) $display("FAIL basic_rd_addr[%0d] got %0d want %0d", i, rd_q[i], i % NT); else passed++;
    end
    total++; if (iss_key.size() != 2 * NT) $display("FAIL basic_issue_count got %0d want %0d", iss_key.size(), 2 * NT); else passed++;
    for (int i = 0; i < iss_key.size() && i < 2 * NT; i++) begin
      total++; if (iss_key[i] != i / NT || iss_coeff[i] !== mem[i % NT])
        $display("FAIL basic_issue[%0d] got key %0d coeff %h want key %0d coeff %h", i, iss_key[i], iss_coeff[i], i / NT, mem[i % NT]);
      else passed++;
      if (i > 0) begin
        total++; if (iss_cyc[i] - iss_cyc[i-1] < 4)
          $display("FAIL basic_spacing[%0d] got %0d want >=4", i, iss_cyc[i] - iss_cyc[i-1]); else passed++;
      end
    end
    total++; if (out_q.size() != exp_q.size()) $display("FAIL basic_out_count got %0d want %0d", out_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) $display("FAIL basic_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL basic_done got %0d want 1", done_cnt); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL basic_err got %b want 0", err_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL basic_idle got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_ready_stall();
    clear_rec(OUTN, OUTN, 1);
    stall_pass = 0; stall_after = 2; stall_len = 10;
    kick();
    run(400);
    total++; if (rd_cyc.size() < 3 || rd_cyc[2] != hold_hi + 1)
      $display("FAIL stall_third_rd got cyc %0d want %0d", rd_cyc.size() < 3 ? -1 : rd_cyc[2], hold_hi + 1);
    else passed++;
    total++; if (iss_key.size() != 2 * NT || rd_q.size() != 2 * NT)
      $display("FAIL stall_counts got issues %0d reads %0d want %0d", iss_key.size(), rd_q.size(), 2 * NT);
    else passed++;
    for (int i = 0; i < iss_coeff.size() && i < 2 * NT; i++) begin
      total++; if (iss_coeff[i] !== mem[i % NT]) $display("FAIL stall_issue[%0d] got %h want %h", i, iss_coeff[i], mem[i % NT]); else passed++;
    end
    total++; if (out_q.size() != exp_q.size()) $display("FAIL stall_out_count got %0d want %0d", out_q.size(), exp_q.size()); else passed++;
    total++; if (done_cnt != 1 || err_o !== 1'b0) $display("FAIL stall_end got done %0d err %b want 1 0", done_cnt, err_o); else passed++;
  endtask

  task automatic test_timeout();
    clear_rec(OUTN, OUTN, 0);
    kick();
    run(400);
    total++; if (iss_cyc.size() < NT || err_rise != iss_cyc[NT-1] + 2 + DTO)
      $display("FAIL timeout_err_cycle got %0d want %0d", err_rise, iss_cyc.size() < NT ? -1 : iss_cyc[NT-1] + 2 + DTO);
    else passed++;
    total++; if (done_cnt != 1) $display("FAIL timeout_done got %0d want 1", done_cnt); else passed++;
    total++; if (err_o !== 1'b1) $display("FAIL timeout_err got %b want 1", err_o); else passed++;
    total++; if (out_q.size() != 2 * OUTN) $display("FAIL timeout_out_count got %0d want %0d", out_q.size(), 2 * OUTN); else passed++;
  endtask

  task automatic test_overflow();
    clear_rec(OUTN + 1, OUTN, 1);
    kick();
    run(400);
    total++; if (exp_reject != 1) $display("FAIL overflow_setup got %0d want 1", exp_reject); else passed++;
    total++; if (out_q.size() != exp_q.size()) $display("FAIL overflow_out_count got %0d want %0d", out_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) $display("FAIL overflow_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); else passed++;
    end
    total++; if (err_o !== 1'b1) $display("FAIL overflow_err got %b want 1", err_o); else passed++;
    total++; if (done_cnt != 1) $display("FAIL overflow_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid_run();
    clear_rec(OUTN, OUTN, 1);
    stall_pass = 1; stall_after = 2; stall_len = 50;
    kick();
    for (int n = 0; n < 400 && pass_issues[1] < 2; n++) step();
    step();
    total++; if (busy_o !== 1'b1 || relin_key_select_o !== 1'b1)
      $display("FAIL midrst_pre got busy %b key %b want 1 1", busy_o, relin_key_select_o); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({busy_o, done_o, err_o, buf_rd_en_o, relin_valid_o, relin_key_select_o, out_valid_o} !== 7'b0)
      $display("FAIL midrst_ctrl got %b want 0000000", {busy_o, done_o, err_o, buf_rd_en_o, relin_valid_o, relin_key_select_o, out_valid_o});
    else passed++;
    total++; if ({relin_coeff_o, out_coeff_o, out_tile_idx_o, out_key_select_o, buf_rd_addr_o} !== '0)
      $display("FAIL midrst_buses got nonzero want zero"); else passed++;
    clear_rec(OUTN, OUTN, 1);
    step();
    rst = 1'b0;
    step();
    kick();
    run(400);
    total++; if (rd_q.size() < 1 || rd_q[0] != 0 || iss_key.size() < 1 || iss_key[0] != 0)
      $display("FAIL midrst_restart got first addr %0d key %0d want 0 0",
               rd_q.size() ? rd_q[0] : -1, iss_key.size() ? iss_key[0] : -1);
    else passed++;
    total++; if (rd_q.size() != 2 * NT || done_cnt != 1 || err_o !== 1'b0)
      $display("FAIL midrst_run got reads %0d done %0d err %b want %0d 1 0", rd_q.size(), done_cnt, err_o, 2 * NT);
    else passed++;
  endtask

  task automatic test_idle_and_busy_start();
    clear_rec(OUTN, OUTN, 1);
    relin_out_valid_i = 1'b1;
    relin_out_coeff_i = rand_tile();
    step();
    total++; if (err_o !== 1'b1) $display("FAIL idle_out_err got %b want 1", err_o); else passed++;
    total++; if (out_q.size() != 0) $display("FAIL idle_out_fwd got %0d want 0", out_q.size()); else passed++;
    kick();
    total++; if (err_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL start_clears_err got err %b busy %b want 0 1", err_o, busy_o); else passed++;
    for (int n = 0; n < 200 && pass_issues[0] < 2; n++) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run(400);
    total++; if (rd_q.size() != 2 * NT) $display("FAIL busy_start_reads got %0d want %0d", rd_q.size(), 2 * NT); else passed++;
    for (int i = 0; i < rd_q.size() && i < 2 * NT; i++) begin
      total++; if (rd_q[i] != i % NT) $display("FAIL busy_start_addr[%0d] got %0d want %0d", i, rd_q[i], i % NT); else passed++;
    end
    total++; if (done_cnt != 1 || err_o !== 1'b0) $display("FAIL busy_start_end got done %0d err %b want 1 0", done_cnt, err_o); else passed++;
  endtask

  initial begin
    cyc = 0;
    clear_rec(OUTN, OUTN, 1);
    test_reset();
    test_basic();
    test_ready_stall();
    test_timeout();
    test_overflow();
    test_reset_mid_run();
    test_idle_and_busy_start();
    test_basic();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
